// File: rtl/qdec_pkg.sv
// qdec_pkg: AB state encoding, direction constants and transition classifier for quad_decoder
package qdec_pkg;
  typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S11 = 2'b11, S10 = 2'b10} ab_t;
  typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DN, MV_ILL} mv_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  function automatic mv_t decode(ab_t p, ab_t n);
    return (p == n) ? MV_NONE : ((p ^ n) == 2'b11) ? MV_ILL : (p[1] ^ n[0]) ? MV_UP : MV_DN;
  endfunction
endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder pins, count control and decoder outputs; master drives pins/controls, slave is the decoder
interface quad_decoder_if #(parameter int N = 8);
  logic         quad_a_i;
  logic         quad_b_i;
  logic         en_i;
  logic         load_i;
  logic [N-1:0] load_val_i;
  logic         err_clr_i;
  logic [N-1:0] count_o;
  logic         step_o;
  logic         dir_o;
  logic         err_o;
  modport master (output quad_a_i, quad_b_i, en_i, load_i, load_val_i, err_clr_i,
                  input count_o, step_o, dir_o, err_o);
  modport slave (input quad_a_i, quad_b_i, en_i, load_i, load_val_i, err_clr_i,
                 output count_o, step_o, dir_o, err_o);
endinterface

// File: rtl/qdec_filter.sv
// qdec_filter: 2-flop synchronizer for one encoder channel plus optional glitch filter (QDEC_FILTER_EN)
// ports: clk, rst_n (sync, active-low), d (async pin), q (synchronized/filtered level)
module qdec_filter
`ifdef QDEC_FILTER_EN
  #(parameter int FILT_LEN = 4)
`endif
  (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync;
  always_ff @(posedge clk)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], d};
`ifdef QDEC_FILTER_EN
  localparam int CW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (sync[1] == q) cnt <= '0;
    else if (cnt == CW'(FILT_LEN - 1)) begin
      q   <= sync[1];
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
`else
  assign q = sync[1];
`endif
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: 4x quadrature decoder with wrapping N-bit position, sync load and sticky error
// ports: clk, rst_n (sync, active-low), bus (quad_decoder_if.slave: pins, en/load/err_clr in; count/step/dir/err out)
// QDEC_FILTER_EN adds a FILT_LEN-cycle glitch filter per channel
module quad_decoder import qdec_pkg::*; #(
  parameter int N        = 8,
  parameter int FILT_LEN = 4
) (
  input logic clk,
  input logic rst_n,
  quad_decoder_if.slave bus
);
`ifdef QDEC_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  // priming waits until the sync/filter pipeline holds a real pin sample,
  // so a level held across reset is never mistaken for a transition
  localparam int WARM = FILT_EN ? 2 + FILT_LEN : 2;
  localparam int WW   = $clog2(WARM + 2);
  logic          a, b, primed, stp;
  logic [WW-1:0] warm;
  ab_t           prev, cur;
  mv_t           mv;
  qdec_filter
`ifdef QDEC_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
    u_fa (.clk(clk), .rst_n(rst_n), .d(bus.quad_a_i), .q(a));
  qdec_filter
`ifdef QDEC_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
    u_fb (.clk(clk), .rst_n(rst_n), .d(bus.quad_b_i), .q(b));
  assign cur = ab_t'({a, b});
  assign mv  = primed ? decode(prev, cur) : MV_NONE;
  assign stp = bus.en_i && (mv == MV_UP || mv == MV_DN);
  always_ff @(posedge clk)
    if (!rst_n) begin
      prev        <= S00;
      primed      <= 1'b0;
      warm        <= '0;
      bus.count_o <= '0;
      bus.step_o  <= 1'b0;
      bus.dir_o   <= DIR_DN;
      bus.err_o   <= 1'b0;
    end else begin
      prev       <= cur;
      primed     <= primed || warm == WW'(WARM);
      warm       <= primed ? warm : warm + 1'b1;
      bus.step_o <= stp;
      bus.dir_o  <= stp ? (mv == MV_UP ? DIR_UP : DIR_DN) : bus.dir_o;
      bus.err_o  <= (mv == MV_ILL) ? 1'b1 : bus.err_clr_i ? 1'b0 : bus.err_o;
      bus.count_o <= bus.load_i ? bus.load_val_i
                   : stp ? (mv == MV_UP ? bus.count_o + 1'b1 : bus.count_o - 1'b1)
                   : bus.count_o;
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized + directed scoreboard bench for quad_decoder
module tb_quad_decoder;
`ifdef QDEC_FILTER_EN
  localparam int PIPE = 6;
  localparam int MINH = 5;
`else
  localparam int PIPE = 2;
  localparam int MINH = 1;
`endif
  logic clk = 1'b0;
  logic rst_n;
  quad_decoder_if #(.N(8)) bus ();
  quad_decoder #(.N(8), .FILT_LEN(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  logic [1:0] m_ab;
  logic [7:0] m_cnt;
  logic       m_dir;
  logic       m_err;
  logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int gidx(logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (gseq[i] == ab) return i;
    return 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && bus.step_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step actual count=%0h dir=%0b expected no step", bus.count_o, bus.dir_o);
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        if ({bus.dir_o, bus.count_o} !== e) begin
          errors++;
          $display("FAIL step actual dir=%0b count=%0h expected dir=%0b count=%0h",
                   bus.dir_o, bus.count_o, e[8], e[7:0]);
        end
      end
    end

  task automatic drive(logic [1:0] ab, int hold);
    int d;
    @(negedge clk);
    {bus.quad_a_i, bus.quad_b_i} = ab;
    d = (gidx(ab) - gidx(m_ab) + 4) % 4;
    m_ab = ab;
    if (d == 2) m_err = 1'b1;
    else if (d != 0 && bus.en_i) begin
      m_cnt = (d == 1) ? m_cnt + 8'd1 : m_cnt - 8'd1;
      m_dir = (d == 1);
      q.push_back({m_dir, m_cnt});
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_count", bus.count_o, 0);
    chk("rst_step", bus.step_o, 0);
    chk("rst_dir", bus.dir_o, 0);
    chk("rst_err", bus.err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 8'h00;
    m_dir = 1'b0;
    m_err = 1'b0;
    q.delete();
    repeat (PIPE + 10) @(negedge clk);
    chk("prime_err", bus.err_o, 0);
    chk("prime_count", bus.count_o, 0);
  endtask

  task automatic do_load(logic [7:0] v);
    @(negedge clk);
    bus.load_i = 1'b1;
    bus.load_val_i = v;
    @(negedge clk);
    bus.load_i = 1'b0;
    m_cnt = v;
    chk("load", bus.count_o, v);
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    m_err = 1'b0;
    chk("err_clr", bus.err_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {bus.quad_a_i, bus.quad_b_i} = 2'b00;
    bus.en_i = 1'b1;
    bus.load_i = 1'b0;
    bus.load_val_i = '0;
    bus.err_clr_i = 1'b0;
    m_ab = 2'b00;
    do_reset();
    // forward
    drive(2'b01, 8);
    drive(2'b11, 8);
    drive(2'b10, 8);
    drive(2'b00, 8);
    chk("fwd_count", bus.count_o, 4);
    chk("fwd_dir", bus.dir_o, 1);
    chk("fwd_err", bus.err_o, 0);
    // reverse with wrap
    do_reset();
    drive(2'b10, 8);
    chk("wrap_count", bus.count_o, 8'hFF);
    chk("wrap_dir", bus.dir_o, 0);
    drive(2'b11, 8);
    drive(2'b01, 8);
    drive(2'b00, 8);
    chk("rev_count", bus.count_o, 8'hFC);
    // load colliding with a forward step
    do_load(8'h10);
    @(negedge clk);
    {bus.quad_a_i, bus.quad_b_i} = 2'b01;
    m_ab = 2'b01;
    repeat (PIPE) @(negedge clk);
    bus.load_i = 1'b1;
    bus.load_val_i = 8'h80;
    m_cnt = 8'h80;
    m_dir = 1'b1;
    q.push_back({1'b1, 8'h80});
    @(negedge clk);
    bus.load_i = 1'b0;
    repeat (PIPE + 4) @(negedge clk);
    chk("collide_count", bus.count_o, 8'h80);
    drive(2'b11, 8);
    chk("after_collide", bus.count_o, 8'h81);
    // illegal transition and clear
    drive(2'b01, 8);
    drive(2'b00, 8);
    drive(2'b11, 8);
    chk("illegal_err", bus.err_o, 1);
    chk("illegal_count", bus.count_o, 8'h7F);
    do_clr();
    drive(2'b00, 8);
    chk("illegal_err2", bus.err_o, 1);
    do_clr();
    // disabled counting
    @(negedge clk);
    bus.en_i = 1'b0;
    drive(2'b01, 8);
    drive(2'b11, 8);
    drive(2'b10, 8);
    drive(2'b00, 8);
    chk("dis_count", bus.count_o, 8'h7F);
    chk("dis_dir", bus.dir_o, 0);
    @(negedge clk);
    bus.en_i = 1'b1;
    repeat (4) @(negedge clk);
`ifdef QDEC_FILTER_EN
    @(negedge clk);
    bus.quad_a_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.quad_a_i = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_count", bus.count_o, 8'h7F);
    drive(2'b10, 12);
    chk("filt_step_count", bus.count_o, 8'h7E);
    drive(2'b00, 12);
`endif
    // randomized walk with occasional illegal jumps
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.en_i = ($urandom_range(0, 3) != 0);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        int r;
        r = $urandom_range(0, 19);
        drive(gseq[(gidx(m_ab) + (r == 0 ? 2 : r < 10 ? 1 : 3)) % 4], MINH + $urandom_range(0, 2));
      end
      repeat (PIPE + 4) @(negedge clk);
      chk("rand_count", bus.count_o, m_cnt);
      chk("rand_dir", bus.dir_o, m_dir);
    end
    chk("rand_err", bus.err_o, m_err);
    do_clr();
    @(negedge clk);
    bus.en_i = 1'b1;
    // level held across reset must not count
    @(negedge clk);
    {bus.quad_a_i, bus.quad_b_i} = 2'b11;
    m_ab = 2'b11;
    do_reset();
    drive(2'b10, 8);
    drive(2'b00, 8);
    chk("post_prime_count", bus.count_o, 2);
    // reset with a step in flight
    @(negedge clk);
    {bus.quad_a_i, bus.quad_b_i} = 2'b01;
    m_ab = 2'b01;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", bus.count_o, 0);
    chk("mid_rst_step", bus.step_o, 0);
    chk("mid_rst_dir", bus.dir_o, 0);
    chk("mid_rst_err", bus.err_o, 0);
    rst_n = 1'b1;
    repeat (PIPE + 10) @(negedge clk);
    chk("mid_rst_hold", bus.count_o, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
